// File: rtl/trap_seq_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// trap cause codes, mstatus/mie bit positions, the sequencer state enum and
// the helpers that compute the mstatus values written on trap entry and on mret.
package trap_seq_pkg;

  // CSR addresses (12-bit CSR space)
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values
  localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
  localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
  localparam logic [31:0] CAUSE_IRQ_TIMER_M = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT_M   = 32'h8000_000B;

  // mstatus / mie bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_WR_MEPC        = 3'd1,
    ST_WR_MCAUSE      = 3'd2,
    ST_WR_MSTATUS     = 3'd3,
    ST_WR_MSTATUS_RET = 3'd4,
    ST_ASSERT         = 3'd5
  } state_e;

  // Trap entry: MPIE <= MIE, MIE <= 0, all other bits preserved.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] mstatus);
    logic [31:0] v;
    v = mstatus;
    v[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    v[MSTATUS_MIE]  = 1'b0;
    return v;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, all other bits preserved.
  function automatic logic [31:0] ret_mstatus(input logic [31:0] mstatus);
    logic [31:0] v;
    v = mstatus;
    v[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    return v;
  endfunction

  // Zero-extend a 12-bit CSR address onto the 32-bit write address bus.
  function automatic logic [31:0] csr_addr32(input logic [11:0] a);
    return {20'd0, a};
  endfunction

endpackage

// File: rtl/trap_seq.sv
// Machine-mode trap sequencer. Detects ecall/ebreak/mret and enabled level
// interrupts while idle, stalls the pipeline, writes mepc/mcause/mstatus
// through the single CSR write port, then issues a one-cycle redirect.
// Optional build macro: TRAP_VECTORED_EN (vectored interrupt dispatch when
// mtvec mode is 2'b01; otherwise the redirect always uses the mtvec base).
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter int IRQ_SYNC_STALL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] next_pc_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  input  logic        debug_halt_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        stall_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_e      state_r, state_nxt_s;
  logic [31:0] epc_r, epc_nxt_s;
  logic [31:0] cause_r, cause_nxt_s;
  logic        ret_r, ret_nxt_s;
  logic        timer_en_s, ext_en_s, event_s;
  logic [31:0] base_s, vec_addr_s;
  logic        unused_ok_s;

  // Only a few mie bits and (in the base build) no mtvec mode bits matter here.
  assign unused_ok_s = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0]};

  // Interrupt qualification and event detection; interrupts are masked in debug.
  always_comb begin
    timer_en_s = timer_irq_i & mie_i[MIE_MTIE] & mstatus_i[MSTATUS_MIE] & ~debug_halt_i;
    ext_en_s   = ext_irq_i & mie_i[MIE_MEIE] & mstatus_i[MSTATUS_MIE] & ~debug_halt_i;
    event_s    = ecall_i | ebreak_i | mret_i | timer_en_s | ext_en_s;
  end

  // Redirect target for trap entry, with optional vectored interrupt offset.
  always_comb begin
    base_s = {mtvec_i[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (cause_r[31] && (mtvec_i[1:0] == 2'b01)) begin
      vec_addr_s = base_s + {26'd0, cause_r[3:0], 2'b00};
    end else begin
      vec_addr_s = base_s;
    end
`else
    vec_addr_s = base_s;
`endif
  end

  // Next-state and capture logic; inputs are only looked at while idle.
  always_comb begin
    state_nxt_s = state_r;
    epc_nxt_s   = epc_r;
    cause_nxt_s = cause_r;
    ret_nxt_s   = ret_r;
    case (state_r)
      ST_IDLE: begin
        if (ecall_i) begin
          state_nxt_s = ST_WR_MEPC;
          epc_nxt_s   = inst_addr_i;
          cause_nxt_s = CAUSE_ECALL_M;
          ret_nxt_s   = 1'b0;
        end else if (ebreak_i) begin
          state_nxt_s = ST_WR_MEPC;
          epc_nxt_s   = inst_addr_i;
          cause_nxt_s = CAUSE_BREAKPOINT;
          ret_nxt_s   = 1'b0;
        end else if (mret_i) begin
          state_nxt_s = ST_WR_MSTATUS_RET;
          ret_nxt_s   = 1'b1;
        end else if (ext_en_s) begin
          state_nxt_s = ST_WR_MEPC;
          epc_nxt_s   = next_pc_i;
          cause_nxt_s = CAUSE_IRQ_EXT_M;
          ret_nxt_s   = 1'b0;
        end else if (timer_en_s) begin
          state_nxt_s = ST_WR_MEPC;
          epc_nxt_s   = next_pc_i;
          cause_nxt_s = CAUSE_IRQ_TIMER_M;
          ret_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_MEPC:        state_nxt_s = ST_WR_MCAUSE;
      ST_WR_MCAUSE:      state_nxt_s = ST_WR_MSTATUS;
      ST_WR_MSTATUS:     state_nxt_s = ST_ASSERT;
      ST_WR_MSTATUS_RET: state_nxt_s = ST_ASSERT;
      ST_ASSERT:         state_nxt_s = ST_IDLE;
      default:           state_nxt_s = ST_IDLE;
    endcase
  end

  // State and capture registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      epc_r   <= 32'd0;
      cause_r <= 32'd0;
      ret_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      epc_r   <= epc_nxt_s;
      cause_r <= cause_nxt_s;
      ret_r   <= ret_nxt_s;
    end
  end

  // Moore output decode; the idle detect-cycle stall is forced low in reset.
  always_comb begin
    we_o         = 1'b0;
    waddr_o      = 32'd0;
    wdata_o      = 32'd0;
    stall_o      = 1'b1;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    case (state_r)
      ST_IDLE: begin
        stall_o = (IRQ_SYNC_STALL != 0) && event_s && rst_n;
      end
      ST_WR_MEPC: begin
        we_o    = 1'b1;
        waddr_o = csr_addr32(CSR_MEPC);
        wdata_o = epc_r;
      end
      ST_WR_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = csr_addr32(CSR_MCAUSE);
        wdata_o = cause_r;
      end
      ST_WR_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = csr_addr32(CSR_MSTATUS);
        wdata_o = trap_mstatus(mstatus_i);
      end
      ST_WR_MSTATUS_RET: begin
        we_o    = 1'b1;
        waddr_o = csr_addr32(CSR_MSTATUS);
        wdata_o = ret_mstatus(mstatus_i);
      end
      ST_ASSERT: begin
        int_assert_o = 1'b1;
        if (ret_r) begin
          int_addr_o = mepc_i;
        end else begin
          int_addr_o = vec_addr_s;
        end
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq: reset, ecall, timer interrupt
// (enabled and masked), mret, sync-vs-interrupt priority, mid-sequence reset
// and the (optionally vectored) external interrupt redirect.
module tb_trap_seq;

  logic        clk, rst_n;
  logic        ecall_i, ebreak_i, mret_i;
  logic [31:0] inst_addr_i, next_pc_i;
  logic        timer_irq_i, ext_irq_i, debug_halt_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i, mie_i;
  logic        we_o, stall_o, int_assert_o;
  logic [31:0] waddr_o, wdata_o, int_addr_o;

  int tests, fails;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        ia;
    logic [31:0] iaddr;
  } cyc_t;

  trap_seq #(.IRQ_SYNC_STALL(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .inst_addr_i(inst_addr_i), .next_pc_i(next_pc_i),
    .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i), .debug_halt_i(debug_halt_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .stall_o(stall_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cyc_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic st, input logic ia, input logic [31:0] ta);
    cyc_t c;
    c.we = we; c.waddr = a; c.wdata = d; c.stall = st; c.ia = ia; c.iaddr = ta;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    inst_addr_i = 32'd0; next_pc_i = 32'd0;
    timer_irq_i = 1'b0; ext_irq_i = 1'b0; debug_halt_i = 1'b0;
    mtvec_i = 32'd0; mepc_i = 32'd0; mstatus_i = 32'd0; mie_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({we_o, stall_o, int_assert_o, waddr_o, wdata_o, int_addr_o} !== 99'd0) begin
      fails++;
      $display("FAIL reset_outputs got we=%0b st=%0b ia=%0b wa=%h wd=%h ta=%h want all 0",
               we_o, stall_o, int_assert_o, waddr_o, wdata_o, int_addr_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({we_o, stall_o, int_assert_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle got we=%0b st=%0b ia=%0b want 000", we_o, stall_o, int_assert_o);
    end
  endtask

  // ecall at 0x100, mtvec 0x2000, mstatus 0x8.
  task automatic test_ecall();
    cyc_t e[6];
    e[0] = mk(1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0);
    e[1] = mk(1'b1, 32'h341, 32'h100, 1'b1, 1'b0, 32'h0);
    e[2] = mk(1'b1, 32'h342, 32'd11,  1'b1, 1'b0, 32'h0);
    e[3] = mk(1'b1, 32'h300, 32'h80,  1'b1, 1'b0, 32'h0);
    e[4] = mk(1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h2000);
    e[5] = mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    inst_addr_i = 32'h100; mtvec_i = 32'h2000; mstatus_i = 32'h8; ecall_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if ({we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o} !==
          {e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr}) begin
        fails++;
        $display("FAIL ecall T+%0d got we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h want we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h",
                 i, we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o,
                 e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr);
      end
      @(posedge clk); #1;
      if (i == 0) ecall_i = 1'b0;
    end
  endtask

  // Timer interrupt taken with MIE=1, then masked by mstatus=0.
  task automatic test_timer();
    cyc_t e[6];
    e[0] = mk(1'b0, 32'h0,   32'h0,         1'b1, 1'b0, 32'h0);
    e[1] = mk(1'b1, 32'h341, 32'h204,       1'b1, 1'b0, 32'h0);
    e[2] = mk(1'b1, 32'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);
    e[3] = mk(1'b1, 32'h300, 32'h80,        1'b1, 1'b0, 32'h0);
    e[4] = mk(1'b0, 32'h0,   32'h0,         1'b1, 1'b1, 32'h2000);
    e[5] = mk(1'b0, 32'h0,   32'h0,         1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    mie_i = 32'h80; mstatus_i = 32'h8; next_pc_i = 32'h204; mtvec_i = 32'h2000;
    timer_irq_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if ({we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o} !==
          {e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr}) begin
        fails++;
        $display("FAIL timer T+%0d got we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h want we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h",
                 i, we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o,
                 e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr);
      end
      @(posedge clk); #1;
      if (i == 3) mstatus_i = 32'h80;
    end
    timer_irq_i = 1'b0;
    mstatus_i = 32'h0;
    timer_irq_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({we_o, stall_o, int_assert_o} !== 3'b000) begin
        fails++;
        $display("FAIL timer_masked cyc%0d got we=%0b st=%0b ia=%0b want 000",
                 i, we_o, stall_o, int_assert_o);
      end
      @(posedge clk); #1;
    end
    timer_irq_i = 1'b0;
  endtask

  // mret with MPIE=1: mstatus 0x80 -> 0x88, redirect to mepc.
  task automatic test_mret();
    cyc_t e[4];
    e[0] = mk(1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h0);
    e[1] = mk(1'b1, 32'h300, 32'h88, 1'b1, 1'b0, 32'h0);
    e[2] = mk(1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h204);
    e[3] = mk(1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    mstatus_i = 32'h80; mepc_i = 32'h204; mret_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o} !==
          {e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr}) begin
        fails++;
        $display("FAIL mret T+%0d got we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h want we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h",
                 i, we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o,
                 e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr);
      end
      @(posedge clk); #1;
      if (i == 0) mret_i = 1'b0;
      if (i == 1) mstatus_i = 32'h88;
    end
    // mret with MPIE=0 restores MIE=0 and still sets MPIE.
    mstatus_i = 32'h0;
    mret_i = 1'b1;
    @(posedge clk); #1;
    mret_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 32'h300, 32'h80}) begin
      fails++;
      $display("FAIL mret_mpie0 got we=%0b wa=%h wd=%h want we=1 wa=300 wd=80",
               we_o, waddr_o, wdata_o);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ecall and enabled ext irq together: ecall wins; irq held but masked afterwards.
  task automatic test_priority();
    cyc_t e[7];
    e[0] = mk(1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0);
    e[1] = mk(1'b1, 32'h341, 32'h300, 1'b1, 1'b0, 32'h0);
    e[2] = mk(1'b1, 32'h342, 32'd11,  1'b1, 1'b0, 32'h0);
    e[3] = mk(1'b1, 32'h300, 32'h80,  1'b1, 1'b0, 32'h0);
    e[4] = mk(1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h2000);
    e[5] = mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0);
    e[6] = mk(1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    mie_i = 32'h800; mstatus_i = 32'h8; mtvec_i = 32'h2000;
    inst_addr_i = 32'h300; next_pc_i = 32'h304;
    ext_irq_i = 1'b1; ecall_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tests++;
      if ({we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o} !==
          {e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr}) begin
        fails++;
        $display("FAIL prio T+%0d got we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h want we=%0b wa=%h wd=%h st=%0b ia=%0b ta=%h",
                 i, we_o, waddr_o, wdata_o, stall_o, int_assert_o, int_addr_o,
                 e[i].we, e[i].waddr, e[i].wdata, e[i].stall, e[i].ia, e[i].iaddr);
      end
      @(posedge clk); #1;
      if (i == 0) ecall_i = 1'b0;
      if (i == 3) mstatus_i = 32'h80;
    end
    ext_irq_i = 1'b0;
    mstatus_i = 32'h8;
  endtask

  // Reset asserted at T+2 clears outputs asynchronously; normal operation resumes.
  task automatic test_reset_mid();
    @(posedge clk); #1;
    mtvec_i = 32'h2000; mstatus_i = 32'h8; inst_addr_i = 32'h400; ecall_i = 1'b1;
    @(posedge clk); #1;
    ecall_i = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({we_o, waddr_o} !== {1'b1, 32'h342}) begin
      fails++;
      $display("FAIL rst_mid_pre got we=%0b wa=%h want we=1 wa=342", we_o, waddr_o);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({we_o, stall_o, int_assert_o} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_async got we=%0b st=%0b ia=%0b want 000", we_o, stall_o, int_assert_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({we_o, stall_o, int_assert_o} !== 3'b000) begin
        fails++;
        $display("FAIL rst_mid_idle cyc%0d got we=%0b st=%0b ia=%0b want 000",
                 i, we_o, stall_o, int_assert_o);
      end
    end
    @(posedge clk); #1;
    ebreak_i = 1'b1; inst_addr_i = 32'h500;
    @(posedge clk); #1;
    ebreak_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 32'h341, 32'h500}) begin
      fails++;
      $display("FAIL rst_mid_after got we=%0b wa=%h wd=%h want we=1 wa=341 wd=500",
               we_o, waddr_o, wdata_o);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // External interrupt and ebreak with mtvec mode bits 2'b01.
  task automatic test_vectored();
    logic [31:0] exp_ext;
`ifdef TRAP_VECTORED_EN
    exp_ext = 32'h202C;
`else
    exp_ext = 32'h2000;
`endif
    @(posedge clk); #1;
    mtvec_i = 32'h2001; mie_i = 32'h800; mstatus_i = 32'h8; next_pc_i = 32'h600;
    ext_irq_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (wdata_o !== 32'h8000_000B) begin
      fails++;
      $display("FAIL vec_ext_cause got %h want 8000000b", wdata_o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mstatus_i = 32'h80;
    ext_irq_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({int_assert_o, int_addr_o} !== {1'b1, exp_ext}) begin
      fails++;
      $display("FAIL vec_ext_addr got ia=%0b ta=%h want ia=1 ta=%h", int_assert_o, int_addr_o, exp_ext);
    end
    @(posedge clk); #1;
    mstatus_i = 32'h8;
    ebreak_i = 1'b1; inst_addr_i = 32'h700;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ebreak_i = 1'b0;
      if (i == 1) begin
        @(negedge clk);
        tests++;
        if (wdata_o !== 32'd3) begin
          fails++;
          $display("FAIL vec_ebreak_cause got %h want 3", wdata_o);
        end
      end
    end
    @(negedge clk);
    tests++;
    if ({int_assert_o, int_addr_o} !== {1'b1, 32'h2000}) begin
      fails++;
      $display("FAIL vec_ebreak_addr got ia=%0b ta=%h want ia=1 ta=2000", int_assert_o, int_addr_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ecall();
    test_timer();
    test_mret();
    test_priority();
    test_reset_mid();
    test_vectored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
